// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multi-cycle MIPS sequencer and its datapath.
// master = controller side, slave = datapath / memory side.
interface mips_multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             ir_write;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             iord;
    logic [1:0]       reg_dst;
    logic [1:0]       mem_to_reg;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_src;
    logic             illegal;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write,
               iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
               illegal, state, instr_count
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write,
               iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
               illegal, state, instr_count
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS-32 control FSM: sequences fetch/decode/execute/mem/writeback
// around a shared ALU and unified memory port, and counts retired instructions.
module mips_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,
    mips_multicycle_ctrl_if.master       bus
);
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11,
        S_HALT      = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t           state_q, state_d;
    logic [5:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             retire;

    logic pc_write_c, pc_write_cond_c, ir_write_c, reg_write_c, mem_write_c;

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    // The IR may change once DECODE is done, so later states use this copy.
    always_ff @(posedge clk) begin
        if (!reset_n)                  op_q <= 6'b0;
        else if (state_q == S_DECODE)  op_q <= bus.opcode;
    end

    assign retire = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_HALT);

    always_ff @(posedge clk) begin
        if (!reset_n)    cnt_q <= '0;
        else if (retire) cnt_q <= cnt_q + 1'b1;
    end

    always_comb begin
        state_d         = state_q;
        pc_write_c      = 1'b0;
        pc_write_cond_c = 1'b0;
        ir_write_c      = 1'b0;
        reg_write_c     = 1'b0;
        mem_write_c     = 1'b0;
        bus.mem_read    = 1'b0;
        bus.iord        = 1'b0;
        bus.reg_dst     = 2'b00;
        bus.mem_to_reg  = 2'b00;
        bus.alu_src_a   = 1'b0;
        bus.alu_src_b   = 2'b00;
        bus.alu_op      = 2'b00;
        bus.pc_src      = 2'b00;
        bus.illegal     = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                ir_write_c    = bus.mem_ready;
                pc_write_c    = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                bus.alu_src_b = 2'b11;
                case (bus.opcode)
                    OP_RTYPE:      state_d = S_R_EXEC;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_J, OP_JAL:  state_d = S_JUMP;
                    OP_ADDI:       state_d = S_I_EXEC;
                    default:       state_d = S_HALT;
                endcase
            end
            S_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
                if (bus.mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write_c    = 1'b1;
                bus.mem_to_reg = 2'b01;
                state_d        = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write_c = 1'b1;
                bus.iord    = 1'b1;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_R_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
                state_d       = S_R_WB;
            end
            S_R_WB: begin
                reg_write_c = 1'b1;
                bus.reg_dst = 2'b01;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_op      = 2'b01;
                pc_write_cond_c = 1'b1;
                bus.pc_src      = 2'b01;
                state_d         = S_FETCH;
            end
            S_JUMP: begin
                pc_write_c = 1'b1;
                bus.pc_src = 2'b10;
                if (op_q == OP_JAL) begin
                    reg_write_c    = 1'b1;
                    bus.reg_dst    = 2'b10;
                    bus.mem_to_reg = 2'b10;
                end
                state_d = S_FETCH;
            end
            S_I_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = S_I_WB;
            end
            S_I_WB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            default: begin
                // HALT and unused encodings both trap until reset.
                bus.illegal = 1'b1;
                state_d     = S_HALT;
            end
        endcase
    end

    // Reset suppresses every write strobe so an abandoned instruction leaves no trace.
    assign bus.pc_write      = pc_write_c      & reset_n;
    assign bus.pc_write_cond = pc_write_cond_c & reset_n;
    assign bus.ir_write      = ir_write_c      & reset_n;
    assign bus.reg_write     = reg_write_c     & reset_n;
    assign bus.mem_write     = mem_write_c     & reset_n;
    assign bus.state         = state_q;
    assign bus.instr_count   = cnt_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: per-scenario tasks with inline checks.
module tb_mips_multicycle_ctrl;
    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    mips_multicycle_ctrl_if #(.CNT_W(32)) bus ();

    mips_multicycle_ctrl #(.CNT_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; bus.mem_ready = 1'b1; bus.opcode = 6'h00;
        cyc();
        #1;
        n_checks++;
        if (bus.state !== 4'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", bus.state); end
        n_checks++;
        if (bus.instr_count !== 32'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.instr_count); end
        n_checks++;
        if ({bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.reg_write, bus.mem_write} !== 5'b0) begin
            n_fail++; $display("FAIL reset_strobes_gated got %b want 00000",
                {bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.reg_write, bus.mem_write});
        end
        reset_n = 1'b1;
        #1;
        n_checks++;
        if ({bus.ir_write, bus.pc_write, bus.mem_read} !== 3'b111) begin
            n_fail++; $display("FAIL fetch_strobes got %b want 111", {bus.ir_write, bus.pc_write, bus.mem_read});
        end
    endtask

    task automatic test_add();
        int exp_st[5];
        logic [31:0] c0;
        exp_st = '{0, 1, 6, 7, 0};
        c0 = bus.instr_count;
        bus.opcode = 6'h00; bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (bus.state !== 4'(exp_st[i])) begin n_fail++; $display("FAIL add_state[%0d] got %0d want %0d", i, bus.state, exp_st[i]); end
            n_checks++;
            if (bus.reg_write !== (exp_st[i] == 7)) begin n_fail++; $display("FAIL add_reg_write[%0d] got %b", i, bus.reg_write); end
            if (exp_st[i] == 7) begin
                n_checks++;
                if (bus.reg_dst !== 2'b01 || bus.mem_to_reg !== 2'b00) begin
                    n_fail++; $display("FAIL add_wb_sel got dst=%b m2r=%b want 01/00", bus.reg_dst, bus.mem_to_reg);
                end
            end
            if (exp_st[i] == 6) begin
                n_checks++;
                if (bus.alu_op !== 2'b10 || bus.alu_src_a !== 1'b1 || bus.alu_src_b !== 2'b00) begin
                    n_fail++; $display("FAIL add_exec_sel got op=%b a=%b b=%b", bus.alu_op, bus.alu_src_a, bus.alu_src_b);
                end
            end
            cyc();
        end
        #1;
        n_checks++;
        if (bus.state !== 4'd0 || bus.instr_count !== c0 + 1) begin
            n_fail++; $display("FAIL add_retire got st=%0d cnt=%0d want 0/%0d", bus.state, bus.instr_count, c0 + 1);
        end
    endtask

    task automatic test_lw_wait();
        int exp_st[8];
        int n_rw;
        logic [31:0] c0;
        exp_st = '{0, 1, 2, 3, 3, 3, 4, 0};
        c0 = bus.instr_count;
        n_rw = 0;
        bus.opcode = 6'h23;
        for (int i = 0; i < 7; i++) begin
            bus.mem_ready = (i == 3 || i == 4) ? 1'b0 : 1'b1;
            if (i == 2) bus.opcode = 6'h2b;  // opcode changes after decode; must be ignored
            #1;
            n_checks++;
            if (bus.state !== 4'(exp_st[i])) begin n_fail++; $display("FAIL lw_state[%0d] got %0d want %0d", i, bus.state, exp_st[i]); end
            if (bus.reg_write === 1'b1) n_rw++;
            if (exp_st[i] == 3) begin
                n_checks++;
                if (bus.mem_read !== 1'b1 || bus.iord !== 1'b1 || bus.mem_write !== 1'b0) begin
                    n_fail++; $display("FAIL lw_memread[%0d] got rd=%b iord=%b wr=%b", i, bus.mem_read, bus.iord, bus.mem_write);
                end
            end
            if (exp_st[i] == 4) begin
                n_checks++;
                if (bus.mem_to_reg !== 2'b01 || bus.reg_dst !== 2'b00) begin
                    n_fail++; $display("FAIL lw_wb_sel got m2r=%b dst=%b want 01/00", bus.mem_to_reg, bus.reg_dst);
                end
            end
            cyc();
        end
        bus.mem_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.state !== 4'd0 || bus.instr_count !== c0 + 1 || n_rw != 1) begin
            n_fail++; $display("FAIL lw_retire got st=%0d cnt=%0d rw=%0d want 0/%0d/1", bus.state, bus.instr_count, n_rw, c0 + 1);
        end
    endtask

    task automatic test_back_to_back();
        int exp_st[8];
        int n_mw, n_pwc;
        logic [31:0] c0;
        exp_st = '{0, 1, 2, 5, 0, 1, 8, 0};
        c0 = bus.instr_count;
        n_mw = 0; n_pwc = 0;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.opcode = (i < 4) ? 6'h2b : 6'h04;
            #1;
            n_checks++;
            if (bus.state !== 4'(exp_st[i])) begin n_fail++; $display("FAIL b2b_state[%0d] got %0d want %0d", i, bus.state, exp_st[i]); end
            if (bus.mem_write === 1'b1) n_mw++;
            if (bus.pc_write_cond === 1'b1) begin
                n_pwc++;
                n_checks++;
                if (bus.pc_src !== 2'b01 || bus.alu_op !== 2'b01) begin
                    n_fail++; $display("FAIL beq_sel got pc_src=%b alu_op=%b want 01/01", bus.pc_src, bus.alu_op);
                end
            end
            cyc();
        end
        #1;
        n_checks++;
        if (n_mw != 1 || n_pwc != 1) begin n_fail++; $display("FAIL b2b_pulses got mw=%0d pwc=%0d want 1/1", n_mw, n_pwc); end
        n_checks++;
        if (bus.state !== 4'd0 || bus.instr_count !== c0 + 2) begin
            n_fail++; $display("FAIL b2b_count got st=%0d cnt=%0d want 0/%0d", bus.state, bus.instr_count, c0 + 2);
        end
    endtask

    task automatic test_jump();
        int exp_st[3];
        logic [5:0] op;
        exp_st = '{0, 1, 9};
        bus.mem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            op = (k == 0) ? 6'h03 : 6'h02;
            for (int i = 0; i < 3; i++) begin
                bus.opcode = (i < 2) ? op : (op ^ 6'h01);  // swap jal/j after decode
                #1;
                n_checks++;
                if (bus.state !== 4'(exp_st[i])) begin n_fail++; $display("FAIL jump%0d_state[%0d] got %0d want %0d", k, i, bus.state, exp_st[i]); end
                if (exp_st[i] == 9) begin
                    n_checks++;
                    if (bus.pc_write !== 1'b1 || bus.pc_src !== 2'b10) begin
                        n_fail++; $display("FAIL jump%0d_pc got pcw=%b src=%b want 1/10", k, bus.pc_write, bus.pc_src);
                    end
                    n_checks++;
                    if (bus.reg_write !== (k == 0)) begin n_fail++; $display("FAIL jump%0d_reg_write got %b want %b", k, bus.reg_write, k == 0); end
                    if (k == 0) begin
                        n_checks++;
                        if (bus.reg_dst !== 2'b10 || bus.mem_to_reg !== 2'b10) begin
                            n_fail++; $display("FAIL jal_link got dst=%b m2r=%b want 10/10", bus.reg_dst, bus.mem_to_reg);
                        end
                    end
                end
                cyc();
            end
            #1;
            n_checks++;
            if (bus.state !== 4'd0) begin n_fail++; $display("FAIL jump%0d_return got %0d want 0", k, bus.state); end
        end
    endtask

    task automatic test_addi();
        int exp_st[4];
        exp_st = '{0, 1, 10, 11};
        bus.opcode = 6'h08; bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (bus.state !== 4'(exp_st[i])) begin n_fail++; $display("FAIL addi_state[%0d] got %0d want %0d", i, bus.state, exp_st[i]); end
            if (exp_st[i] == 10) begin
                n_checks++;
                if (bus.alu_src_a !== 1'b1 || bus.alu_src_b !== 2'b10 || bus.reg_write !== 1'b0) begin
                    n_fail++; $display("FAIL addi_exec got a=%b b=%b rw=%b", bus.alu_src_a, bus.alu_src_b, bus.reg_write);
                end
            end
            if (exp_st[i] == 11) begin
                n_checks++;
                if (bus.reg_write !== 1'b1 || bus.reg_dst !== 2'b00 || bus.mem_to_reg !== 2'b00) begin
                    n_fail++; $display("FAIL addi_wb got rw=%b dst=%b m2r=%b", bus.reg_write, bus.reg_dst, bus.mem_to_reg);
                end
            end
            cyc();
        end
    endtask

    task automatic test_fetch_wait();
        bus.mem_ready = 1'b0; bus.opcode = 6'h00;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (bus.state !== 4'd0 || bus.mem_read !== 1'b1 || bus.ir_write !== 1'b0 || bus.pc_write !== 1'b0) begin
                n_fail++; $display("FAIL fetch_wait[%0d] got st=%0d rd=%b irw=%b pcw=%b", i, bus.state, bus.mem_read, bus.ir_write, bus.pc_write);
            end
            cyc();
        end
        bus.mem_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.ir_write !== 1'b1 || bus.pc_write !== 1'b1) begin
            n_fail++; $display("FAIL fetch_release got irw=%b pcw=%b want 1/1", bus.ir_write, bus.pc_write);
        end
    endtask

    task automatic test_halt();
        logic [31:0] c0;
        c0 = bus.instr_count;
        bus.opcode = 6'h3f; bus.mem_ready = 1'b1;
        cyc();
        cyc();
        for (int i = 0; i < 10; i++) begin
            bus.mem_ready = 1'(i & 1);
            bus.opcode = (i == 5) ? 6'h00 : 6'h3f;
            #1;
            n_checks++;
            if (bus.state !== 4'd15 || bus.illegal !== 1'b1) begin
                n_fail++; $display("FAIL halt_hold[%0d] got st=%0d ill=%b want 15/1", i, bus.state, bus.illegal);
            end
            n_checks++;
            if ({bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.reg_write, bus.mem_write, bus.mem_read} !== 6'b0
                || bus.instr_count !== c0) begin
                n_fail++; $display("FAIL halt_quiet[%0d] got strobes=%b cnt=%0d want 0/%0d", i,
                    {bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.reg_write, bus.mem_write, bus.mem_read}, bus.instr_count, c0);
            end
            cyc();
        end
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1; bus.opcode = 6'h00;
        #1;
        n_checks++;
        if (bus.state !== 4'd0 || bus.illegal !== 1'b0 || bus.instr_count !== 32'd0) begin
            n_fail++; $display("FAIL halt_reset got st=%0d ill=%b cnt=%0d want 0/0/0", bus.state, bus.illegal, bus.instr_count);
        end
    endtask

    task automatic test_reset_mid();
        int exp_st[3];
        logic seen_rw;
        exp_st = '{0, 1, 6};
        seen_rw = 1'b0;
        bus.opcode = 6'h00; bus.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (bus.state !== 4'(exp_st[i])) begin n_fail++; $display("FAIL rmid_state[%0d] got %0d want %0d", i, bus.state, exp_st[i]); end
            seen_rw |= bus.reg_write;
            if (i == 2) reset_n = 1'b0;
            #1;
            seen_rw |= bus.reg_write;
            cyc();
        end
        #1;
        n_checks++;
        if (bus.state !== 4'd0 || bus.instr_count !== 32'd0) begin
            n_fail++; $display("FAIL rmid_abandon got st=%0d cnt=%0d want 0/0", bus.state, bus.instr_count);
        end
        reset_n = 1'b1; bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            seen_rw |= bus.reg_write;
            cyc();
        end
        n_checks++;
        if (seen_rw !== 1'b0) begin n_fail++; $display("FAIL rmid_no_reg_write got %b want 0", seen_rw); end
        bus.mem_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_wait();
        test_back_to_back();
        test_jump();
        test_addi();
        test_fetch_wait();
        test_halt();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
